// File: rtl/clock_pkg.sv
// Shared types, field widths and wrap-around helpers for the clock mode controller.
package clock_pkg;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;

  localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
  localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;

  typedef enum logic [1:0] {
    RUN,
    SET_TIME,
    SET_ALARM,
    RING
  } mode_e;

  // DB_BLOCK is the post-reset state: a key must be seen released before it can fire.
  typedef enum logic [1:0] {
    DB_IDLE,
    DB_HELD,
    DB_BLOCK
  } db_state_e;

  function automatic logic [MIN_W-1:0] step_min(input logic [MIN_W-1:0] v, input logic up);
    if (up) return (v == MAX_MIN) ? '0 : v + 1'b1;
    else    return (v == '0) ? MAX_MIN : v - 1'b1;
  endfunction

  function automatic logic [HOUR_W-1:0] step_hour(input logic [HOUR_W-1:0] v, input logic up);
    if (up) return (v == MAX_HOUR) ? '0 : v + 1'b1;
    else    return (v == '0) ? MAX_HOUR : v - 1'b1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer plus debounce for one active-low key; emits one-cycle press pulses.
// Optional hold-to-repeat is built only when CLOCK_AUTO_REPEAT_EN is defined.
module btn_debounce
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int              DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  // The synchronizer resets high for two cycles, so a shorter debounce could not keep
  // a key held through reset blocked.
  if (DEBOUNCE_CYCLES < 3 || REPEAT_CYCLES < 1) begin : g_bad_cfg
    $error("btn_debounce: DEBOUNCE_CYCLES must be >= 3 and REPEAT_CYCLES >= 1");
  end

  logic            sync1_q, sync2_q;
  db_state_e       st_q;
  logic [DB_W-1:0] cnt_q;
  logic            press_q;
  logic            db_done_w;
  logic            rep_fire_w;

  assign db_done_w = (cnt_q == DB_LAST);

`ifdef CLOCK_AUTO_REPEAT_EN
  localparam int              RP_W    = $clog2(REPEAT_CYCLES + 1);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_CYCLES - 1);

  logic [RP_W-1:0] rep_q;

  assign rep_fire_w = (st_q == DB_HELD) && !sync2_q && (rep_q == RP_LAST);

  always_ff @(posedge clk) begin
    if (rst || st_q != DB_HELD || sync2_q || rep_fire_w) rep_q <= '0;
    else                                                 rep_q <= rep_q + 1'b1;
  end
`else
  assign rep_fire_w = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: non-blocking assignments here so every flop samples pre-edge values;
      // blocking would collapse the synchronizer into a single stage.
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      st_q    <= DB_BLOCK;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
      press_q <= rep_fire_w;
      case (st_q)
        DB_IDLE: begin
          if (sync2_q) begin
            cnt_q <= '0;
          end else if (db_done_w) begin
            press_q <= 1'b1;
            st_q    <= DB_HELD;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          if (!sync2_q) begin
            cnt_q <= '0;
          end else if (db_done_w) begin
            st_q  <= DB_IDLE;
            cnt_q <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/clock_mode_ctrl.sv
// Alarm-clock mode controller: set-time/set-alarm editing, alarm match and ring timer.
// Define CLOCK_AUTO_REPEAT_EN to enable hold-to-repeat on the four edit keys.
module clock_mode_ctrl
  import clock_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int RING_SECONDS    = 60,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sec_tick,
  input  logic [HOUR_W-1:0] cur_hour,
  input  logic [MIN_W-1:0]  cur_min,
  input  logic              time_mode_switch,
  input  logic              alarm_mode_switch,
  input  logic              min_select_switch,
  input  logic              hour_select_switch,
  input  logic              incr_min_btn,
  input  logic              dec_min_btn,
  input  logic              incr_hour_btn,
  input  logic              dec_hour_btn,
  output logic              tc_min_inc,
  output logic              tc_min_dec,
  output logic              tc_hour_inc,
  output logic              tc_hour_dec,
  output logic              tc_hold,
  output logic [HOUR_W-1:0] alarm_hour,
  output logic [MIN_W-1:0]  alarm_min,
  output logic              disp_sel,
  output logic [17:0]       alarm_signal,
  output logic              settings_signal
);

  localparam int              RC_W      = $clog2(RING_SECONDS + 1);
  localparam logic [RC_W-1:0] RING_LAST = RC_W'(RING_SECONDS - 1);

  logic [3:0] keys_n_w;  // {dec_hour, incr_hour, dec_min, incr_min}
  logic [3:0] ev_w;

  assign keys_n_w = {dec_hour_btn, incr_hour_btn, dec_min_btn, incr_min_btn};

  for (genvar k = 0; k < 4; k++) begin : g_key
    btn_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_db (
      .clk     (clk),
      .rst     (rst),
      .btn_n_i (keys_n_w[k]),
      .press_o (ev_w[k])
    );
  end

  mode_e             state_q, state_d;
  logic              tc_min_inc_q, tc_min_dec_q, tc_hour_inc_q, tc_hour_dec_q;
  logic              tc_hold_q, disp_sel_q, settings_q;
  logic [HOUR_W-1:0] alarm_hour_q;
  logic [MIN_W-1:0]  alarm_min_q;
  logic [17:0]       alarm_sig_q;
  logic [RC_W-1:0]   ring_cnt_q;
  logic              match_q, match_prev_q;

  // Opposing keys on one field in the same cycle cancel out.
  logic min_inc_w, min_dec_w, hour_inc_w, hour_dec_w;
  assign min_inc_w  = ev_w[0] & ~ev_w[1] & min_select_switch;
  assign min_dec_w  = ev_w[1] & ~ev_w[0] & min_select_switch;
  assign hour_inc_w = ev_w[2] & ~ev_w[3] & hour_select_switch;
  assign hour_dec_w = ev_w[3] & ~ev_w[2] & hour_select_switch;

  logic match_rise_w, ring_done_w;
  assign match_rise_w = match_q & ~match_prev_q;
  assign ring_done_w  = sec_tick && (ring_cnt_q == RING_LAST);

  always_comb begin
    // NOTE: default first so every path assigns state_d and no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (time_mode_switch)       state_d = SET_TIME;
        else if (alarm_mode_switch) state_d = SET_ALARM;
        else if (match_rise_w)      state_d = RING;
      end
      SET_TIME: if (!time_mode_switch) state_d = RUN;
      SET_ALARM: begin
        if (time_mode_switch)        state_d = SET_TIME;
        else if (!alarm_mode_switch) state_d = RUN;
      end
      RING: begin
        if (time_mode_switch)              state_d = SET_TIME;
        else if (alarm_mode_switch)        state_d = SET_ALARM;
        else if ((|ev_w) || ring_done_w)   state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      tc_min_inc_q  <= 1'b0;
      tc_min_dec_q  <= 1'b0;
      tc_hour_inc_q <= 1'b0;
      tc_hour_dec_q <= 1'b0;
      tc_hold_q     <= 1'b0;
      disp_sel_q    <= 1'b0;
      settings_q    <= 1'b0;
      alarm_hour_q  <= '0;
      alarm_min_q   <= '0;
      alarm_sig_q   <= '0;
      ring_cnt_q    <= '0;
      // A match already present when reset releases is treated as old.
      match_q       <= 1'b1;
      match_prev_q  <= 1'b1;
    end else begin
      state_q       <= state_d;
      tc_min_inc_q  <= (state_q == SET_TIME) & min_inc_w;
      tc_min_dec_q  <= (state_q == SET_TIME) & min_dec_w;
      tc_hour_inc_q <= (state_q == SET_TIME) & hour_inc_w;
      tc_hour_dec_q <= (state_q == SET_TIME) & hour_dec_w;
      tc_hold_q     <= (state_d == SET_TIME);
      disp_sel_q    <= (state_d == SET_ALARM);
      settings_q    <= (state_d == SET_TIME) || (state_d == SET_ALARM);
      match_q       <= ({cur_hour, cur_min} == {alarm_hour_q, alarm_min_q});
      match_prev_q  <= match_q;

      if (state_q == SET_ALARM) begin
        if (min_inc_w || min_dec_w)   alarm_min_q  <= step_min(alarm_min_q, min_inc_w);
        if (hour_inc_w || hour_dec_w) alarm_hour_q <= step_hour(alarm_hour_q, hour_inc_w);
      end

      if (state_d != RING) begin
        ring_cnt_q  <= '0;
        alarm_sig_q <= '0;
      end else if (state_q != RING) begin
        ring_cnt_q  <= '0;
        alarm_sig_q <= '1;
      end else if (sec_tick) begin
        ring_cnt_q  <= ring_cnt_q + 1'b1;
        alarm_sig_q <= ~alarm_sig_q;
      end
    end
  end

  assign tc_min_inc      = tc_min_inc_q;
  assign tc_min_dec      = tc_min_dec_q;
  assign tc_hour_inc     = tc_hour_inc_q;
  assign tc_hour_dec     = tc_hour_dec_q;
  assign tc_hold         = tc_hold_q;
  assign alarm_hour      = alarm_hour_q;
  assign alarm_min       = alarm_min_q;
  assign disp_sel        = disp_sel_q;
  assign alarm_signal    = alarm_sig_q;
  assign settings_signal = settings_q;

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Self-checking bench for clock_mode_ctrl: randomized key presses against an arithmetic
// model of the alarm fields and time-counter command counts, plus directed ring scenarios.
module tb_clock_mode_ctrl;

  localparam int D  = 4;
  localparam int RS = 3;
  localparam int RP = 16;
`ifdef CLOCK_AUTO_REPEAT_EN
  localparam int HOLD60_EVENTS = 4;
`else
  localparam int HOLD60_EVENTS = 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, sec_tick;
  logic [4:0]  cur_hour;
  logic [5:0]  cur_min;
  logic        time_mode_switch, alarm_mode_switch, min_select_switch, hour_select_switch;
  logic        incr_min_btn, dec_min_btn, incr_hour_btn, dec_hour_btn;
  logic        tc_min_inc, tc_min_dec, tc_hour_inc, tc_hour_dec, tc_hold;
  logic [4:0]  alarm_hour;
  logic [5:0]  alarm_min;
  logic        disp_sel, settings_signal;
  logic [17:0] alarm_signal;

  clock_mode_ctrl #(
    .DEBOUNCE_CYCLES (D),
    .RING_SECONDS    (RS),
    .REPEAT_CYCLES   (RP)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .sec_tick           (sec_tick),
    .cur_hour           (cur_hour),
    .cur_min            (cur_min),
    .time_mode_switch   (time_mode_switch),
    .alarm_mode_switch  (alarm_mode_switch),
    .min_select_switch  (min_select_switch),
    .hour_select_switch (hour_select_switch),
    .incr_min_btn       (incr_min_btn),
    .dec_min_btn        (dec_min_btn),
    .incr_hour_btn      (incr_hour_btn),
    .dec_hour_btn       (dec_hour_btn),
    .tc_min_inc         (tc_min_inc),
    .tc_min_dec         (tc_min_dec),
    .tc_hour_inc        (tc_hour_inc),
    .tc_hour_dec        (tc_hour_dec),
    .tc_hold            (tc_hold),
    .alarm_hour         (alarm_hour),
    .alarm_min          (alarm_min),
    .disp_sel           (disp_sel),
    .alarm_signal       (alarm_signal),
    .settings_signal    (settings_signal)
  );

  int n_checks = 0;
  int n_errors = 0;
  int tc_seen[4] = '{0, 0, 0, 0};
  int exp_tc[4]  = '{0, 0, 0, 0};
  int long_pulses = 0;
  logic [3:0] tc_prev = '0;
  int exp_min = 0;
  int exp_hour = 0;

  // Command pulse monitor: counts pulses and flags any that last more than one cycle.
  always @(negedge clk) begin
    logic [3:0] now_v;
    now_v = {tc_hour_dec, tc_hour_inc, tc_min_dec, tc_min_inc};
    for (int i = 0; i < 4; i++) if (now_v[i]) tc_seen[i]++;
    if ((now_v & tc_prev) != 4'b0) long_pulses++;
    tc_prev = now_v;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_keys(input logic [3:0] m);
    incr_min_btn  = ~m[0];
    dec_min_btn   = ~m[1];
    incr_hour_btn = ~m[2];
    dec_hour_btn  = ~m[3];
  endtask

  task automatic press(input logic [3:0] m, input int hold, input bit bounce);
    if (bounce) begin
      set_keys(m); tick(2);
      set_keys(4'b0); tick(1);
    end
    set_keys(m); tick(hold);
    set_keys(4'b0); tick(D + 5);
  endtask

  // Reference behaviour of one accepted press on the current switch settings.
  task automatic model(input logic [3:0] m, input bit in_alarm);
    bit im, dm, ih, dh;
    im = m[0] && !m[1] && min_select_switch;
    dm = m[1] && !m[0] && min_select_switch;
    ih = m[2] && !m[3] && hour_select_switch;
    dh = m[3] && !m[2] && hour_select_switch;
    if (in_alarm) begin
      if (im) exp_min = (exp_min + 1) % 60;
      if (dm) exp_min = (exp_min + 59) % 60;
      if (ih) exp_hour = (exp_hour + 1) % 24;
      if (dh) exp_hour = (exp_hour + 23) % 24;
    end else begin
      exp_tc[0] += int'(im); exp_tc[1] += int'(dm);
      exp_tc[2] += int'(ih); exp_tc[3] += int'(dh);
    end
  endtask

  task automatic press_m(input logic [3:0] m, input int hold, input bit bounce, input bit in_alarm);
    press(m, hold, bounce);
    model(m, in_alarm);
  endtask

  task automatic goto_alarm(input int h, input int mn);
    hour_select_switch = 1'b1; min_select_switch = 1'b0;
    while (exp_hour != h)
      press_m(((h - exp_hour + 24) % 24 <= 12) ? 4'b0100 : 4'b1000, D + 2, 1'b0, 1'b1);
    hour_select_switch = 1'b0; min_select_switch = 1'b1;
    while (exp_min != mn)
      press_m(((mn - exp_min + 60) % 60 <= 30) ? 4'b0001 : 4'b0010, D + 2, 1'b0, 1'b1);
  endtask

  task automatic check_tc(input string tag);
    check({tag, "_min_inc"},  tc_seen[0], exp_tc[0]);
    check({tag, "_min_dec"},  tc_seen[1], exp_tc[1]);
    check({tag, "_hour_inc"}, tc_seen[2], exp_tc[2]);
    check({tag, "_hour_dec"}, tc_seen[3], exp_tc[3]);
  endtask

  task automatic wait_ring(input string tag);
    int c;
    c = 0;
    while (alarm_signal == 18'h0 && c < 10) begin tick(1); c++; end
    check(tag, alarm_signal, 18'h3FFFF);
  endtask

  task automatic sec_pulse();
    sec_tick = 1'b1; tick(1);
    sec_tick = 1'b0; tick(1);
  endtask

  initial begin
    rst = 1'b1; sec_tick = 1'b0; cur_hour = 5'd12; cur_min = 6'd0;
    time_mode_switch = 1'b0; alarm_mode_switch = 1'b0;
    min_select_switch = 1'b0; hour_select_switch = 1'b0;
    set_keys(4'b0);
    tick(3);
    check("reset_ctrl", {tc_min_inc, tc_min_dec, tc_hour_inc, tc_hour_dec, tc_hold, disp_sel, settings_signal}, 0);
    check("reset_alarm", {alarm_hour, alarm_min}, 0);
    check("reset_led", alarm_signal, 0);
    rst = 1'b0; tick(D + 5);
    check("run_ctrl", {tc_hold, disp_sel, settings_signal, alarm_signal}, 0);

    // Both switches high: set-time wins; dropping it moves on to set-alarm.
    time_mode_switch = 1'b1; alarm_mode_switch = 1'b1; tick(2);
    check("prio_flags", {settings_signal, disp_sel, tc_hold}, 3'b101);
    time_mode_switch = 1'b0; tick(3);
    check("set_alarm_flags", {settings_signal, disp_sel, tc_hold}, 3'b110);

    min_select_switch = 1'b1; hour_select_switch = 1'b0;
    press_m(4'b0010, D + 2, 1'b0, 1'b1);
    check("min_dec_wrap", alarm_min, exp_min);
    press_m(4'b0001, D + 2, 1'b0, 1'b1);
    check("min_inc_wrap", alarm_min, exp_min);
    check("min_inc_wrap_hour", alarm_hour, exp_hour);

    for (int i = 0; i < 14; i++) begin
      min_select_switch  = 1'($urandom_range(0, 1));
      hour_select_switch = 1'($urandom_range(0, 1));
      press_m(4'($urandom_range(1, 15)), D + 2 + int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b1);
      check("rand_alarm_min", alarm_min, exp_min);
      check("rand_alarm_hour", alarm_hour, exp_hour);
    end

    goto_alarm(23, exp_min);
    hour_select_switch = 1'b1;
    press_m(4'b0100, D + 2, 1'b0, 1'b1);
    check("hour_inc_wrap", alarm_hour, exp_hour);
    check_tc("alarm_no_tc");

    alarm_mode_switch = 1'b0; tick(2);
    check("back_to_run", {settings_signal, disp_sel, tc_hold}, 3'b000);

    time_mode_switch = 1'b1; tick(2);
    check("set_time_flags", {settings_signal, disp_sel, tc_hold}, 3'b101);
    hour_select_switch = 1'b0; min_select_switch = 1'b1;
    press_m(4'b0100, D + 2, 1'b0, 1'b0);
    check("hour_gated", tc_seen[2], exp_tc[2]);
    press_m(4'b0010, D + 2, 1'b0, 1'b0);
    check("min_dec_cmd", tc_seen[1], exp_tc[1]);
    check("hold_in_set_time", tc_hold, 1'b1);
    press_m(4'b0001, 6, 1'b1, 1'b0);
    check("bounce_one_event", tc_seen[0], exp_tc[0]);
    for (int i = 0; i < 10; i++) begin
      min_select_switch  = 1'($urandom_range(0, 1));
      hour_select_switch = 1'($urandom_range(0, 1));
      press_m(4'($urandom_range(1, 15)), D + 2 + int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
      check_tc("rand_tc");
    end
    check("tc_one_cycle", long_pulses, 0);
    check("time_edit_alarm", {alarm_hour, alarm_min}, {exp_hour[4:0], exp_min[5:0]});
    time_mode_switch = 1'b0; tick(2);

    // Alarm match and ring sequence.
    alarm_mode_switch = 1'b1; tick(2);
    goto_alarm(7, 30);
    alarm_mode_switch = 1'b0; tick(2);
    cur_hour = 5'd7; cur_min = 6'd29; tick(4);
    check("no_ring_yet", alarm_signal, 0);
    cur_min = 6'd30;
    wait_ring("ring_start");
    sec_pulse(); check("ring_tick1", alarm_signal, 18'h0);
    sec_pulse(); check("ring_tick2", alarm_signal, 18'h3FFFF);
    sec_pulse(); check("ring_tick3_end", {settings_signal, alarm_signal}, 0);
    sec_pulse(); sec_pulse(); tick(5);
    check("no_reringing", alarm_signal, 0);

    cur_min = 6'd31; tick(3); cur_min = 6'd30;
    wait_ring("ring2_start");
    press(4'b1000, D + 2, 1'b0);
    check("press_exit_led", alarm_signal, 0);
    check("press_exit_hour", alarm_hour, exp_hour);
    check("press_exit_min", alarm_min, exp_min);

    cur_min = 6'd31; tick(3); cur_min = 6'd30;
    wait_ring("ring3_start");
    alarm_mode_switch = 1'b1; tick(2);
    check("ring_to_set_alarm", {disp_sel, settings_signal, alarm_signal}, 20'h80000 | 20'h40000);
    alarm_mode_switch = 1'b0; tick(2);

    cur_min = 6'd31; tick(3); cur_min = 6'd30;
    wait_ring("ring4_start");
    rst = 1'b1; tick(1);
    check("rst_in_ring_ctrl", {tc_min_inc, tc_min_dec, tc_hour_inc, tc_hour_dec, tc_hold, disp_sel, settings_signal}, 0);
    check("rst_in_ring_led", alarm_signal, 0);
    check("rst_in_ring_alarm", {alarm_hour, alarm_min}, 0);
    exp_hour = 0; exp_min = 0;

    // Key held across reset must be released before it counts.
    set_keys(4'b0001); alarm_mode_switch = 1'b1; min_select_switch = 1'b1; hour_select_switch = 1'b0;
    tick(2); rst = 1'b0; tick(30);
    set_keys(4'b0); tick(D + 5);
    check("held_through_reset", alarm_min, exp_min);

    set_keys(4'b0001); tick(60);
    set_keys(4'b0); tick(D + 5);
    exp_min = (exp_min + HOLD60_EVENTS) % 60;
    check("hold_60_cycles", alarm_min, exp_min);
    check_tc("final_tc");
    check("final_one_cycle", long_pulses, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/clock_mode_ctrl.md
CLOCK_MODE_CTRL -- requirements
Module: clock_mode_ctrl

Interface
REQ-001 SHALL have parameters, one per line:
  DEBOUNCE_CYCLES, default 500000, stable-low cycles to accept a press
  RING_SECONDS, default 60, alarm ring duration in sec_tick pulses
  REPEAT_CYCLES, default 12500000, auto-repeat period
REQ-002 SHALL have ports, one per line:
  clk  in  1  system clock, single domain
  rst  in  1  synchronous, active-high reset
  sec_tick  in  1  one-cycle pulse, 1 Hz
  cur_hour  in  5  time counter hours, 0..23
  cur_min  in  6  time counter minutes, 0..59
  time_mode_switch  in  1  set-time request
  alarm_mode_switch  in  1  set-alarm request
  min_select_switch  in  1  enable minute editing
  hour_select_switch  in  1  enable hour editing
  incr_min_btn, dec_min_btn, incr_hour_btn, dec_hour_btn  in  1 each  raw keys, active-low, asynchronous
  tc_min_inc, tc_min_dec, tc_hour_inc, tc_hour_dec  out  1 each  one-cycle commands to time counter
  tc_hold  out  1  freezes time counter seconds
  alarm_hour  out  5  stored alarm hour
  alarm_min  out  6  stored alarm minute
  disp_sel  out  1  0 = show time, 1 = show alarm
  alarm_signal  out  18  LED bar
  settings_signal  out  1  high in any set state

Function
REQ-003 Each key SHALL pass a 2-flop synchronizer, then debounce; one press event = one-cycle pulse after DEBOUNCE_CYCLES consecutive low samples; no further event until key stable-high DEBOUNCE_CYCLES.
REQ-004 FSM states SHALL be RUN, SET_TIME, SET_ALARM, RING.
REQ-005 RUN->SET_TIME when time_mode_switch=1; RUN->SET_ALARM when alarm_mode_switch=1 and time_mode_switch=0; time_mode_switch has priority.
REQ-006 SET_TIME/SET_ALARM SHALL return to RUN the cycle after their switch drops; SET_ALARM->SET_TIME if time_mode_switch rises.
REQ-007 In SET_TIME: min press events SHALL drive tc_min_inc/dec only if min_select_switch=1; hour events only if hour_select_switch=1; tc_hold=1.
REQ-008 In SET_ALARM: same gating edits alarm_min/alarm_hour; inc 59->0, dec 0->59 (min); inc 23->0, dec 0->23 (hour); no carry between fields; disp_sel=1.
REQ-009 Simultaneous inc and dec events on one field SHALL be ignored; min and hour events in one cycle SHALL both apply.
REQ-010 tc_* outputs SHALL be registered: 1-cycle latency after press event, exactly 1 cycle high.
REQ-011 RUN->RING when {cur_hour,cur_min} becomes equal to {alarm_hour,alarm_min} (rising edge of match, registered compare); a match persisting after leaving RING SHALL NOT re-trigger.
REQ-012 RING: alarm_signal SHALL be all-ones/all-zeros toggling on each sec_tick, starting all-ones; exit to RUN after RING_SECONDS sec_ticks or any press event (event consumed, no edit); mode switch high SHALL exit to its set state next cycle.
REQ-013 Outside RING alarm_signal=0; settings_signal=1 only in SET_TIME/SET_ALARM; disp_sel=1 only in SET_ALARM.

Reset
REQ-014 rst SHALL force: state RUN, all tc_* 0, tc_hold 0, alarm_hour 0, alarm_min 0, disp_sel 0, alarm_signal 0, settings_signal 0, debounce counters/sync flops idle-high, ring counter 0.
REQ-015 rst mid-press or mid-ring SHALL abort with no command pulse emitted; a key still held after reset SHALL need full release before a new event.

Configuration
REQ-016 Macro CLOCK_AUTO_REPEAT_EN: defined -> a key held past one REPEAT_CYCLES generates a further press event every REPEAT_CYCLES while held; undefined -> exactly one event per press, repeat counter absent.

Structure
REQ-017 Package clock_pkg SHALL hold the state enum, HOUR_W=5, MIN_W=6, MAX_HOUR=23, MAX_MIN=59.
REQ-018 Sub-module btn_debounce (sync+debounce+optional repeat) SHALL be instantiated four times.

Verification (DEBOUNCE_CYCLES=4, RING_SECONDS=3, REPEAT_CYCLES=16)
REQ-019 SET_ALARM, min select, alarm_min=59, one incr_min press -> alarm_min=0, alarm_hour unchanged.
REQ-020 SET_TIME, hour select=0, incr_hour press -> no tc_hour_inc; min select=1, dec_min press -> single 1-cycle tc_min_dec, tc_hold=1.
REQ-021 Key bounce low 2 cycles/high 1/low 6 -> exactly one event.
REQ-022 alarm 07:30, cur moves 07:29->07:30 -> RING, alarm_signal 0x3FFFF, toggles per sec_tick, RUN after 3 ticks; match held -> no re-ring.
REQ-023 RING then dec_hour press -> RUN, alarm_hour unchanged; rst asserted in RING -> all outputs 0 next cycle.
REQ-024 With CLOCK_AUTO_REPEAT_EN, incr_min held 60 cycles in SET_ALARM -> 1 + 3 increments; without -> 1.
